vec_addsub_sequencer: RTL and testbench

// - Multi-cycle sequencer for the 32-bit SIMD adder/subtractor (8/16/32-bit lanes) in the vector execution unit.
// - Accepts one vector add/sub op of VLEN bits.
// - Streams it through the adder one 32-bit word per cycle and assembles vd with vl tail handling.
// - Returns vd to the issue stage over a valid/ack handshake.

---
 rtl/vec_addsub_sequencer.sv | 139 +++++++++++++
 tb/tb_vec_addsub_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vec_addsub_sequencer.sv
// Multi-cycle sequencer feeding a 32-bit SIMD add/sub unit one word per cycle and assembling vd with vl tail handling.
// Build option: define VEC_ADDSUB_EARLY_TERM_EN to stop after the last word that holds active elements.
//
// state | meaning
// IDLE  | ready for a new op
// BUSY  | driving word w through the adder, merging the sum into vd
// DONE  | vd_o/error_o valid, waiting for done_ack_i
module vec_addsub_sequencer #(
    parameter int VLEN = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic                      ready_o,
    input  logic                      op_sub_i,
    input  logic [1:0]                sew_i,
    input  logic [$clog2(VLEN/8):0]   vl_i,
    input  logic [VLEN-1:0]           vs1_i,
    input  logic [VLEN-1:0]           vs2_i,
    input  logic [VLEN-1:0]           vd_old_i,
    output logic                      add_ctrl_o,
    output logic                      add_sew_16_32_o,
    output logic                      add_sew_32_o,
    output logic [31:0]               add_a_o,
    output logic [31:0]               add_b_o,
    input  logic [31:0]               add_sum_i,
    output logic [VLEN-1:0]           vd_o,
    output logic                      done_o,
    output logic                      error_o,
    input  logic                      done_ack_i
);
    localparam int NUM_WORDS = VLEN / 32;
    localparam int VW        = $clog2(VLEN/8) + 1;
    localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [WW-1:0]     w;
    logic [WW-1:0]     last_w;
    logic [VLEN-1:0]   vs1_q, vs2_q, vd_q;
    logic              op_q, error_q;
    logic [1:0]        sew_q;
    logic [VW-1:0]     vl_q;
    logic [31:0]       merged;
    logic [VW:0]       byte_idx, elem;

`ifdef VEC_ADDSUB_EARLY_TERM_EN
    logic [VW-1:0]     max_el, vl_eff;
    logic [VW+1:0]     nbytes;

    always_comb begin
        case (sew_q)
            2'b00:   max_el = VW'(VLEN/8);
            2'b01:   max_el = VW'(VLEN/16);
            default: max_el = VW'(VLEN/32);
        endcase
        vl_eff = (vl_q > max_el) ? max_el : vl_q;
        nbytes = (VW+2)'(vl_eff) << sew_q;
        // vl_q is nonzero whenever BUSY is reached, so nbytes >= 1 there
        last_w = WW'((nbytes - (VW+2)'(1)) >> 2);
    end
`else
    assign last_w = WW'(NUM_WORDS - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = (vl_i == '0 || sew_i == 2'b11) ? DONE : BUSY;
            BUSY: if (w == last_w) state_nxt = DONE;
            DONE: if (done_ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_ctrl_o      = 1'b0;
        add_sew_16_32_o = 1'b0;
        add_sew_32_o    = 1'b0;
        add_a_o         = '0;
        add_b_o         = '0;
        if (state == BUSY) begin
            add_ctrl_o      = op_q;
            add_sew_16_32_o = (sew_q != 2'b00);
            add_sew_32_o    = (sew_q == 2'b10);
            add_a_o         = vs2_q[w*32 +: 32];
            add_b_o         = vs1_q[w*32 +: 32];
        end
    end

    // Element index e < vl implies e < vl_eff, since e never exceeds VLEN/SEW-1
    always_comb begin
        merged   = vd_q[w*32 +: 32];
        byte_idx = '0;
        elem     = '0;
        for (int j = 0; j < 4; j++) begin
            byte_idx = (VW+1)'({w, 2'(j)});
            elem     = byte_idx >> sew_q;
            if (elem < {1'b0, vl_q}) merged[j*8 +: 8] = add_sum_i[j*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            op_q    <= 1'b0;
            sew_q   <= 2'b00;
            vl_q    <= '0;
            error_q <= 1'b0;
            w       <= '0;
        end else if (state == IDLE && start_i) begin
            vs1_q   <= vs1_i;
            vs2_q   <= vs2_i;
            vd_q    <= vd_old_i;
            op_q    <= op_sub_i;
            sew_q   <= sew_i;
            vl_q    <= vl_i;
            error_q <= (sew_i == 2'b11);
            w       <= '0;
        end else if (state == BUSY) begin
            vd_q[w*32 +: 32] <= merged;
            w                <= w + WW'(1);
        end
    end

    assign ready_o = (state == IDLE);
    assign done_o  = (state == DONE);
    assign error_o = (state == DONE) && error_q;
    assign vd_o    = (state == DONE) ? vd_q : '0;

endmodule

// File: tb/tb_vec_addsub_sequencer.sv
// Directed bench for vec_addsub_sequencer with a behavioural SIMD adder attached to the add_* pins.
module tb_vec_addsub_sequencer;
    localparam int VLEN = 128;
    localparam int VW   = $clog2(VLEN/8) + 1;
`ifdef VEC_ADDSUB_EARLY_TERM_EN
    localparam int LAT_HW3  = 3;
    localparam int LAT_W2   = 3;
`else
    localparam int LAT_HW3  = 5;
    localparam int LAT_W2   = 5;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic            ready_o;
    logic            op_sub_i = 1'b0;
    logic [1:0]      sew_i = 2'b00;
    logic [VW-1:0]   vl_i = '0;
    logic [VLEN-1:0] vs1_i = '0, vs2_i = '0, vd_old_i = '0;
    logic            add_ctrl_o, add_sew_16_32_o, add_sew_32_o;
    logic [31:0]     add_a_o, add_b_o, add_sum_i;
    logic [VLEN-1:0] vd_o;
    logic            done_o, error_o;
    logic            done_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_addsub_sequencer #(.VLEN(VLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o),
        .op_sub_i(op_sub_i), .sew_i(sew_i), .vl_i(vl_i),
        .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_old_i(vd_old_i),
        .add_ctrl_o(add_ctrl_o), .add_sew_16_32_o(add_sew_16_32_o), .add_sew_32_o(add_sew_32_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_sum_i(add_sum_i),
        .vd_o(vd_o), .done_o(done_o), .error_o(error_o), .done_ack_i(done_ack_i)
    );

    // Lane-wrapping adder: 8/16/32-bit lanes, 0 for the unused 10 encoding
    always_comb begin
        add_sum_i = '0;
        case ({add_sew_32_o, add_sew_16_32_o})
            2'b00: for (int i = 0; i < 4; i++)
                add_sum_i[i*8 +: 8] = add_ctrl_o ? add_a_o[i*8 +: 8] - add_b_o[i*8 +: 8]
                                                 : add_a_o[i*8 +: 8] + add_b_o[i*8 +: 8];
            2'b01: for (int i = 0; i < 2; i++)
                add_sum_i[i*16 +: 16] = add_ctrl_o ? add_a_o[i*16 +: 16] - add_b_o[i*16 +: 16]
                                                   : add_a_o[i*16 +: 16] + add_b_o[i*16 +: 16];
            2'b11: add_sum_i = add_ctrl_o ? add_a_o - add_b_o : add_a_o + add_b_o;
            default: add_sum_i = '0;
        endcase
    end

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, wait for done_o (cycle 1 = first cycle after accept)
    task automatic run_op(input logic sub, input logic [1:0] sew, input logic [VW-1:0] vl,
                          input logic [VLEN-1:0] a, input logic [VLEN-1:0] b, input logic [VLEN-1:0] old,
                          output int cyc, output logic [1:0] pins, output logic act);
        @(negedge clk);
        op_sub_i = sub; sew_i = sew; vl_i = vl;
        vs2_i = a; vs1_i = b; vd_old_i = old;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i  = 1'b0;
        op_sub_i = ~sub;
        vl_i     = ~vl;
        vs1_i    = {$urandom, $urandom, $urandom, $urandom};
        vs2_i    = {$urandom, $urandom, $urandom, $urandom};
        vd_old_i = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1; pins = 2'b00; act = 1'b0;
        while (!done_o && cyc < 40) begin
            if (cyc == 1) pins = {add_sew_32_o, add_sew_16_32_o};
            act = act | (|{add_a_o, add_b_o, add_ctrl_o, add_sew_32_o, add_sew_16_32_o});
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic ack_op();
        @(negedge clk);
        done_ack_i = 1'b1;
        @(posedge clk); #1;
        check("ack_ready", 128'(ready_o), 128'(1'b1));
        @(negedge clk);
        done_ack_i = 1'b0;
    endtask

    int          cyc;
    logic [1:0]  pins;
    logic        act;
    logic        stable;
    logic        saw_done;

    initial begin
        #1;
        check("rst_ready", 128'(ready_o), 128'(1'b1));
        check("rst_outs", {vd_o, done_o, error_o, add_a_o, add_b_o, add_ctrl_o, add_sew_16_32_o, add_sew_32_o} == '0 ? 128'(1) : 128'(0), 128'(1));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 32-bit add with wrap in the top word
        run_op(1'b0, 2'b10, VW'(4), 128'hFFFFFFFF_00000003_00000002_00000001, {4{32'h1}}, '0, cyc, pins, act);
        check("w32_lat", 128'(cyc), 128'(5));
        check("w32_vd", vd_o, 128'h00000000_00000004_00000003_00000002);
        check("w32_pins", 128'(pins), 128'(2'b11));
        check("w32_err", 128'(error_o), 128'(1'b0));
        ack_op();

        // 8-bit subtract: no borrow between bytes
        run_op(1'b1, 2'b00, VW'(16), '0, {16{8'h01}}, '0, cyc, pins, act);
        check("b8_lat", 128'(cyc), 128'(5));
        check("b8_vd", vd_o, {16{8'hFF}});
        check("b8_pins", 128'(pins), 128'(2'b00));

        // Hold without ack: outputs stable, start ignored
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_i = 1'b1; sew_i = 2'b10; vl_i = VW'(4);
            @(posedge clk); #1;
            if (done_o !== 1'b1 || ready_o !== 1'b0 || vd_o !== {16{8'hFF}}) stable = 1'b0;
        end
        @(negedge clk);
        start_i = 1'b0;
        check("hold_stable", 128'(stable), 128'(1'b1));
        ack_op();

        // Back-to-back: 16-bit add with tail at vl=3
        run_op(1'b0, 2'b01, VW'(3), {8{16'h7FFF}}, {8{16'h0001}}, {8{16'hAAAA}}, cyc, pins, act);
        check("h16_lat", 128'(cyc), 128'(LAT_HW3));
        check("h16_vd", vd_o, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_8000_8000_8000);
        check("h16_pins", 128'(pins), 128'(2'b01));
        ack_op();

        // 32-bit sub, vl=2: upper words keep vd_old
        run_op(1'b1, 2'b10, VW'(2), 128'd40 << 96 | 128'd30 << 64 | 128'd20 << 32 | 128'd10,
               128'd4 << 96 | 128'd3 << 64 | 128'd2 << 32 | 128'd1, {4{32'h55555555}}, cyc, pins, act);
        check("w32t_lat", 128'(cyc), 128'(LAT_W2));
        check("w32t_vd", vd_o, 128'h55555555_55555555_00000012_00000009);
        ack_op();

        // vl=0 bypass
        run_op(1'b0, 2'b00, VW'(0), {16{8'h11}}, {16{8'h22}}, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, cyc, pins, act);
        check("vl0_lat", 128'(cyc), 128'(1));
        check("vl0_vd", vd_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("vl0_err", 128'(error_o), 128'(1'b0));
        ack_op();

        // Illegal sew
        run_op(1'b1, 2'b11, VW'(5), {16{8'h11}}, {16{8'h22}}, {4{32'hDEADBEEF}}, cyc, pins, act);
        check("sew3_lat", 128'(cyc), 128'(1));
        check("sew3_err", 128'(error_o), 128'(1'b1));
        check("sew3_vd", vd_o, {4{32'hDEADBEEF}});
        check("sew3_noadd", 128'(act), 128'(1'b0));
        ack_op();

        // Reset during BUSY word 2
        @(negedge clk);
        op_sub_i = 1'b0; sew_i = 2'b10; vl_i = VW'(4);
        vs2_i = {4{32'h10}}; vs1_i = {4{32'h1}}; vd_old_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 128'(ready_o), 128'(1'b1));
        check("mid_rst_outs", {vd_o, done_o, error_o, add_a_o, add_b_o, add_ctrl_o, add_sew_16_32_o, add_sew_32_o} == '0 ? 128'(1) : 128'(0), 128'(1));
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0) saw_done = 1'b1;
        end
        check("mid_rst_nodone", 128'(saw_done), 128'(1'b0));

        run_op(1'b0, 2'b10, VW'(4), 128'hFFFFFFFF_00000003_00000002_00000001, {4{32'h1}}, '0, cyc, pins, act);
        check("post_rst_lat", 128'(cyc), 128'(5));
        check("post_rst_vd", vd_o, 128'h00000000_00000004_00000003_00000002);
        ack_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
